ext_bus_responder: RTL and testbench
====================================

// Module: ext_bus_responder
// PURPOSE
//  Slave-side model/responder for the DSP external memory bus: decodes PMSn/DMSn/IOSn/BMSn
//  with RDn/WRn and EA, serves reads onto ED and commits writes into internal PM/DM arrays
//  and an IO register file. Used as on-board external memory and in EMC verification.
//  Flags protocol violations and counts completed accesses.
// PARAMETERS
//  AW      10  array address width; PM and DM arrays hold 2**AW 16-bit words each
//  RD_LAT  1   posedges from first sampled read strobe to valid read data (1..15)
//  NIOREG  16  IO registers, addressed by EA[3:0]
// PORTS
//  DSPCLK     in   1   clock
//  PPclr      in   1   reset, asynchronous, active-high
//  EA         in   15  external address
//  ED_in      in   16  external data from the bus master
//  PMSn       in   1   program memory select, active-low
//  DMSn       in   1   data memory select, active-low
//  IOSn       in   1   IO select, active-low
//  BMSn       in   1   boot memory select, active-low; aliased to PM array
//  RDn        in   1   read strobe, active-low
//  WRn        in   1   write strobe, active-low
//  rsp_ED_do  out  16  read data
//  rsp_ED_oe  out  1   read data drive enable
//  err_stat   out  4   sticky errors: [0] RDn&WRn low, [1] >1 select low, [2] early read end, [3] EA changed mid-access
//  err_clr    in   1   clears err_stat (error set in same cycle wins)
//  rd_cnt     out  16  completed reads, saturating at 16'hFFFF
//  wr_cnt     out  16  committed writes, saturating at 16'hFFFF
// BEHAVIOUR
//  Reset: state IDLE; rsp_ED_oe=0; rsp_ED_do=0; err_stat=0; rd_cnt=wr_cnt=0; IO regs=0; arrays not reset.
//  sel = any of PMSn/DMSn/IOSn/BMSn low. Priority PM>BM>DM>IO when several are low (err[1] also set).
//  FSM, evaluated at each DSPCLK posedge:
//  - IDLE: sel & !RDn -> RWAIT; latch EA and space; lat_cnt=1.
//          sel & !WRn -> WACT; latch EA and space; wbuf=ED_in.
//          RDn and WRn both low -> err[0]; stay IDLE.
//  - RWAIT: lat_cnt==RD_LAT -> RDRV, rsp_ED_do=array data; else lat_cnt++.
//          !sel | RDn -> err[2]; TURN; no rd_cnt increment.
//  - RDRV: rsp_ED_oe = (state==RDRV) & sel & !RDn; combinational, drops in the same cycle the
//          strobe releases. rsp_ED_do is held stable.
//          sel & !RDn stays -> RDRV. Otherwise rd_cnt++ and TURN.
//  - WACT: wbuf=ED_in every cycle while sel & !WRn.
//          First posedge sampling WRn high or !sel -> commit wbuf at the latched address; wr_cnt++; TURN.
//  - TURN: one cycle with rsp_ED_oe=0, then IDLE. A new strobe sampled here is taken in IDLE next cycle.
//  Address decode, with a=latched EA:
//  - PM/BM: PM[a[AW-1:0]].
//  - DM: DM[a[AW-1:0]].
//  - IO: a[10:4]==0 -> reg[a[3:0]]; otherwise reads return 16'h0000 and writes are dropped, but are still counted.
//  EA differing from the latched value while in RWAIT/RDRV/WACT -> err[3]. The access continues on the latched address.
//  Write followed by an immediate read of the same address returns the new data.
//  PPclr mid-access: oe drops asynchronously, a pending write is discarded, counters and errors are cleared.
//  Counters saturate and never wrap.
// TESTING
//  - DM write 16'hA5C3 @EA=0x0012 (WRn low 2 cycles), then read with RD_LAT=1 -> rsp_ED_do=16'hA5C3, oe only while RDn low, rd_cnt=1, wr_cnt=1.
//  - RD_LAT=3, RDn low for 2 cycles -> err_stat=4'b0100, rd_cnt unchanged, oe never asserted; err_clr -> 4'b0000.
//  - IO write 16'h1234 to EA=0x0005, read back 16'h1234; read EA=0x0025 -> 16'h0000; wr_cnt=2.
//  - PMSn and DMSn both low with a read -> PM data returned, err_stat[1]=1; RDn and WRn both low -> err_stat[0]=1, no commit.
//  - PPclr asserted in WACT -> oe=0 immediately, target word unchanged, counters 0; access after reset works.
//  - Preload rd_cnt=16'hFFFE, then 3 reads -> rd_cnt=16'hFFFF.

Source files
------------

// File: rtl/ext_bus_responder.sv
// Slave responder for the DSP external memory bus: serves PM/DM/IO reads and writes,
// flags protocol violations and counts completed accesses.
module ext_bus_responder #(
   parameter int unsigned AW     = 10,
   parameter int unsigned RD_LAT = 1,
   parameter int unsigned NIOREG = 16
) (
   input  logic        DSPCLK,
   input  logic        PPclr,
   input  logic [14:0] EA,
   input  logic [15:0] ED_in,
   input  logic        PMSn,
   input  logic        DMSn,
   input  logic        IOSn,
   input  logic        BMSn,
   input  logic        RDn,
   input  logic        WRn,
   output logic [15:0] rsp_ED_do,
   output logic        rsp_ED_oe,
   output logic [3:0]  err_stat,
   input  logic        err_clr,
   output logic [15:0] rd_cnt,
   output logic [15:0] wr_cnt
);

   typedef enum logic [2:0] {IDLE, RWAIT, RDRV, WACT, TURN} state_t;
   typedef enum logic [1:0] {SP_PM, SP_DM, SP_IO} space_t;

   state_t        state, state_nxt;
   space_t        space_q, space_dec;
   logic [14:0]   ea_q;
   logic [3:0]    lat_cnt;
   logic [15:0]   wbuf;
   logic [15:0]   rd_data;
   logic [15:0]   pm_mem [2**AW];
   logic [15:0]   dm_mem [2**AW];
   logic [15:0]   io_reg [NIOREG];

   logic          sel, multi_sel, rd_req, wr_req;
   logic          latch, lat_inc, load_do, rd_done, wr_commit, wbuf_load;
   logic [3:0]    err_set;
   logic          io_hit;
   logic [3:0]    io_idx;
   logic [AW-1:0] mem_idx;

   always_comb begin
      sel       = ~(PMSn & DMSn & IOSn & BMSn);
      multi_sel = $countones(~{PMSn, DMSn, IOSn, BMSn}) > 1;
      rd_req    = sel & ~RDn;
      wr_req    = sel & ~WRn;
      // BMSn aliases the PM array, so it ranks alongside PM ahead of DM and IO
      if (!PMSn || !BMSn)
         space_dec = SP_PM;
      else if (!DMSn)
         space_dec = SP_DM;
      else
         space_dec = SP_IO;
   end

   always_comb begin
      mem_idx = ea_q[AW-1:0];
      io_idx  = ea_q[3:0];
      io_hit  = (ea_q[10:4] == '0) && ({28'd0, io_idx} < NIOREG);
      case (space_q)
         SP_PM:   rd_data = pm_mem[mem_idx];
         SP_DM:   rd_data = dm_mem[mem_idx];
         default: rd_data = io_hit ? io_reg[io_idx] : '0;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      latch      = 1'b0;
      lat_inc    = 1'b0;
      load_do    = 1'b0;
      rd_done    = 1'b0;
      wr_commit  = 1'b0;
      wbuf_load  = 1'b0;
      err_set    = '0;
      err_set[1] = multi_sel;
      err_set[3] = (state == RWAIT || state == RDRV || state == WACT) && (EA != ea_q);
      case (state)
         IDLE: begin
            if (sel && !RDn && !WRn) begin
               err_set[0] = 1'b1;
            end else if (rd_req) begin
               state_nxt = RWAIT;
               latch     = 1'b1;
            end else if (wr_req) begin
               state_nxt = WACT;
               latch     = 1'b1;
               wbuf_load = 1'b1;
            end
         end
         RWAIT: begin
            if (!rd_req) begin
               err_set[2] = 1'b1;
               state_nxt  = TURN;
            end else if (lat_cnt == 4'(RD_LAT)) begin
               state_nxt = RDRV;
               load_do   = 1'b1;
            end else begin
               lat_inc = 1'b1;
            end
         end
         RDRV: begin
            if (!rd_req) begin
               rd_done   = 1'b1;
               state_nxt = TURN;
            end
         end
         WACT: begin
            if (wr_req) begin
               wbuf_load = 1'b1;
            end else begin
               wr_commit = 1'b1;
               state_nxt = TURN;
            end
         end
         default: state_nxt = IDLE;
      endcase
      rsp_ED_oe = (state == RDRV) && rd_req;
   end

   always_ff @(posedge DSPCLK or posedge PPclr) begin
      if (PPclr) begin
         state     <= IDLE;
         space_q   <= SP_PM;
         ea_q      <= '0;
         lat_cnt   <= '0;
         wbuf      <= '0;
         rsp_ED_do <= '0;
         err_stat  <= '0;
         rd_cnt    <= '0;
         wr_cnt    <= '0;
         for (int unsigned i = 0; i < NIOREG; i++)
            io_reg[i] <= '0;
      end else begin
         state <= state_nxt;
         if (latch) begin
            ea_q    <= EA;
            space_q <= space_dec;
            lat_cnt <= 4'd1;
         end else if (lat_inc) begin
            lat_cnt <= lat_cnt + 4'd1;
         end
         if (wbuf_load)
            wbuf <= ED_in;
         if (load_do)
            rsp_ED_do <= rd_data;
         // a newly detected error wins over a simultaneous clear
         err_stat <= (err_clr ? 4'b0000 : err_stat) | err_set;
         if (rd_done && rd_cnt != '1)
            rd_cnt <= rd_cnt + 16'd1;
         if (wr_commit && wr_cnt != '1)
            wr_cnt <= wr_cnt + 16'd1;
         if (wr_commit && space_q == SP_IO && io_hit)
            io_reg[io_idx] <= wbuf;
      end
   end

   always_ff @(posedge DSPCLK) begin
      if (wr_commit && space_q == SP_PM)
         pm_mem[mem_idx] <= wbuf;
      if (wr_commit && space_q == SP_DM)
         dm_mem[mem_idx] <= wbuf;
   end

endmodule

// File: tb/tb_ext_bus_responder.sv
// Bench for ext_bus_responder: directed transaction table, corner-case sequences,
// and randomized transactions checked against a transaction-level memory model.
module tb_ext_bus_responder;

   logic        DSPCLK = 1'b0;
   logic        PPclr;
   logic [14:0] EA;
   logic [15:0] ED_in;
   logic [3:0]  sel_n, sel3_n;   // [0]=PMSn [1]=DMSn [2]=IOSn [3]=BMSn
   logic        RDn, WRn, err_clr;

   logic [15:0] do1, rdc1, wrc1, do3, rdc3, wrc3;
   logic        oe1, oe3;
   logic [3:0]  err1, err3;

   always #5 DSPCLK = ~DSPCLK;

   ext_bus_responder #(.AW(10), .RD_LAT(1), .NIOREG(16)) u1 (
      .DSPCLK(DSPCLK), .PPclr(PPclr), .EA(EA), .ED_in(ED_in),
      .PMSn(sel_n[0]), .DMSn(sel_n[1]), .IOSn(sel_n[2]), .BMSn(sel_n[3]),
      .RDn(RDn), .WRn(WRn), .rsp_ED_do(do1), .rsp_ED_oe(oe1), .err_stat(err1),
      .err_clr(err_clr), .rd_cnt(rdc1), .wr_cnt(wrc1));

   ext_bus_responder #(.AW(10), .RD_LAT(3), .NIOREG(16)) u3 (
      .DSPCLK(DSPCLK), .PPclr(PPclr), .EA(EA), .ED_in(ED_in),
      .PMSn(sel3_n[0]), .DMSn(sel3_n[1]), .IOSn(sel3_n[2]), .BMSn(sel3_n[3]),
      .RDn(RDn), .WRn(WRn), .rsp_ED_do(do3), .rsp_ED_oe(oe3), .err_stat(err3),
      .err_clr(err_clr), .rd_cnt(rdc3), .wr_cnt(wrc3));

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic        wr;
      logic [3:0]  sel;
      logic [14:0] ea;
      logic [15:0] data;
      int unsigned hold;
      logic [15:0] exp_rd;
      logic [15:0] exp_wr;
      logic [3:0]  exp_err;
   } vec_t;

   vec_t tbl[16];

   logic [15:0] m_pm [int unsigned];
   logic [15:0] m_dm [int unsigned];
   logic [15:0] m_io [16];
   logic [15:0] m_rd, m_wr;
   logic [3:0]  m_err;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_state(input string tag, input logic [15:0] rd, input logic [15:0] wr,
                              input logic [3:0] err);
      check({tag, " rd_cnt"}, rdc1, rd);
      check({tag, " wr_cnt"}, wrc1, wr);
      check({tag, " err_stat"}, 16'(err1), 16'(err));
   endtask

   // one read on u1 with RDn sampled low on h posedges; data valid from the 2nd sample
   task automatic bus_read(input logic [3:0] s, input logic [14:0] a, input int unsigned h,
                           input logic chk, input logic [15:0] exp);
      @(negedge DSPCLK);
      sel_n = s; EA = a; RDn = 1'b0;
      for (int unsigned k = 1; k <= h; k++) begin
         @(negedge DSPCLK);
         check("rd oe", 16'(oe1), 16'(k >= 2));
         if (chk && k >= 2)
            check("rd data", do1, exp);
      end
      RDn = 1'b1; sel_n = 4'hF;
      #1 check("oe release", 16'(oe1), 16'd0);
      @(negedge DSPCLK);
      @(negedge DSPCLK);
   endtask

   // one write on u1 held for w posedges; only the last sampled ED value must land
   task automatic bus_write(input logic [3:0] s, input logic [14:0] a, input logic [15:0] d,
                            input int unsigned w);
      @(negedge DSPCLK);
      sel_n = s; EA = a; WRn = 1'b0;
      ED_in = (w == 1) ? d : 16'($urandom);
      for (int unsigned k = 1; k <= w; k++) begin
         @(negedge DSPCLK);
         check("wr oe", 16'(oe1), 16'd0);
         if (k < w)
            ED_in = (k + 1 == w) ? d : 16'($urandom);
      end
      WRn = 1'b1; sel_n = 4'hF; ED_in = 16'($urandom);
      @(negedge DSPCLK);
      @(negedge DSPCLK);
   endtask

   task automatic pulse_clr();
      @(negedge DSPCLK);
      err_clr = 1'b1;
      @(negedge DSPCLK);
      err_clr = 1'b0;
   endtask

   function automatic int resolve(input logic [3:0] s);
      if (!s[0] || !s[3]) return 0;
      if (!s[1]) return 1;
      return 2;
   endfunction

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [3:0] sel_tab[7];
      sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1100, 4'b0011, 4'b1001};

      //            wr    sel      ea        data      hold rd     wr     err
      tbl[0]  = '{1'b1, 4'b1101, 15'h0012, 16'hA5C3, 2, 16'd0,  16'd1, 4'b0000};
      tbl[1]  = '{1'b0, 4'b1101, 15'h0012, 16'hA5C3, 2, 16'd1,  16'd1, 4'b0000};
      tbl[2]  = '{1'b1, 4'b1011, 15'h0005, 16'h1234, 1, 16'd1,  16'd2, 4'b0000};
      tbl[3]  = '{1'b0, 4'b1011, 15'h0005, 16'h1234, 2, 16'd2,  16'd2, 4'b0000};
      tbl[4]  = '{1'b0, 4'b1011, 15'h0025, 16'h0000, 3, 16'd3,  16'd2, 4'b0000};
      tbl[5]  = '{1'b1, 4'b1110, 15'h0040, 16'hBEEF, 1, 16'd3,  16'd3, 4'b0000};
      tbl[6]  = '{1'b0, 4'b0111, 15'h0040, 16'hBEEF, 2, 16'd4,  16'd3, 4'b0000};
      tbl[7]  = '{1'b1, 4'b1101, 15'h0040, 16'h1111, 3, 16'd4,  16'd4, 4'b0000};
      tbl[8]  = '{1'b0, 4'b1100, 15'h0040, 16'hBEEF, 2, 16'd5,  16'd4, 4'b0010};
      tbl[9]  = '{1'b0, 4'b1101, 15'h0040, 16'h1111, 2, 16'd6,  16'd4, 4'b0010};
      tbl[10] = '{1'b1, 4'b1011, 15'h0035, 16'h7777, 1, 16'd6,  16'd5, 4'b0010};
      tbl[11] = '{1'b0, 4'b1011, 15'h0035, 16'h0000, 2, 16'd7,  16'd5, 4'b0010};
      tbl[12] = '{1'b0, 4'b1011, 15'h0005, 16'h1234, 2, 16'd8,  16'd5, 4'b0010};
      tbl[13] = '{1'b0, 4'b1101, 15'h0412, 16'hA5C3, 2, 16'd9,  16'd5, 4'b0010};
      tbl[14] = '{1'b1, 4'b0111, 15'h0413, 16'hCAFE, 2, 16'd9,  16'd6, 4'b0010};
      tbl[15] = '{1'b0, 4'b1110, 15'h0013, 16'hCAFE, 2, 16'd10, 16'd6, 4'b0010};

      PPclr = 1'b1; EA = '0; ED_in = '0; sel_n = 4'hF; sel3_n = 4'hF;
      RDn = 1'b1; WRn = 1'b1; err_clr = 1'b0;
      #1;
      check("reset oe", 16'(oe1), 16'd0);
      check("reset do", do1, 16'd0);
      check_state("reset", 16'd0, 16'd0, 4'b0000);
      check("reset u3 do", do3, 16'd0);
      @(negedge DSPCLK);
      @(negedge DSPCLK);
      PPclr = 1'b0;

      for (int i = 0; i < 16; i++) begin
         if (tbl[i].wr)
            bus_write(tbl[i].sel, tbl[i].ea, tbl[i].data, tbl[i].hold);
         else
            bus_read(tbl[i].sel, tbl[i].ea, tbl[i].hold, 1'b1, tbl[i].data);
         check_state($sformatf("tbl%0d", i), tbl[i].exp_rd, tbl[i].exp_wr, tbl[i].exp_err);
      end

      // error clear, then clear coinciding with a fresh multi-select error
      pulse_clr();
      check("clr", 16'(err1), 16'd0);
      @(negedge DSPCLK);
      sel_n = 4'b1100; err_clr = 1'b1;
      @(negedge DSPCLK);
      sel_n = 4'hF; err_clr = 1'b0;
      check("clr vs set", 16'(err1), 16'(4'b0010));
      pulse_clr();

      // RDn and WRn both low: error only, nothing committed
      @(negedge DSPCLK);
      sel_n = 4'b1101; EA = 15'h0012; ED_in = 16'hDEAD; RDn = 1'b0; WRn = 1'b0;
      @(negedge DSPCLK);
      check("rw oe", 16'(oe1), 16'd0);
      @(negedge DSPCLK);
      RDn = 1'b1; WRn = 1'b1; sel_n = 4'hF;
      @(negedge DSPCLK);
      @(negedge DSPCLK);
      check_state("rw both", 16'd10, 16'd6, 4'b0001);
      bus_read(4'b1101, 15'h0012, 2, 1'b1, 16'hA5C3);
      check_state("rw nocommit", 16'd11, 16'd6, 4'b0001);
      pulse_clr();

      // EA moves while driving: flagged, data stays from the latched address
      @(negedge DSPCLK);
      sel_n = 4'b1101; EA = 15'h0012; RDn = 1'b0;
      @(negedge DSPCLK);
      @(negedge DSPCLK);
      check("ea oe", 16'(oe1), 16'd1);
      check("ea data", do1, 16'hA5C3);
      EA = 15'h0013;
      @(negedge DSPCLK);
      check("ea moved data", do1, 16'hA5C3);
      RDn = 1'b1; sel_n = 4'hF; EA = 15'h0012;
      @(negedge DSPCLK);
      @(negedge DSPCLK);
      check_state("ea moved", 16'd12, 16'd6, 4'b1000);
      pulse_clr();

      // RD_LAT=3 instance: early read end, then a full-latency read
      @(negedge DSPCLK);
      sel3_n = 4'b1101; EA = 15'h0020; RDn = 1'b0;
      for (int k = 1; k <= 2; k++) begin
         @(negedge DSPCLK);
         check("lat3 early oe", 16'(oe3), 16'd0);
      end
      RDn = 1'b1; sel3_n = 4'hF;
      @(negedge DSPCLK);
      check("lat3 early oe end", 16'(oe3), 16'd0);
      @(negedge DSPCLK);
      check("lat3 early err", 16'(err3), 16'(4'b0100));
      check("lat3 early rd_cnt", rdc3, 16'd0);
      pulse_clr();
      check("lat3 clr", 16'(err3), 16'd0);
      @(negedge DSPCLK);
      sel3_n = 4'b1011; EA = 15'h0003; ED_in = 16'h3C3C; WRn = 1'b0;
      @(negedge DSPCLK);
      WRn = 1'b1; sel3_n = 4'hF;
      @(negedge DSPCLK);
      @(negedge DSPCLK);
      @(negedge DSPCLK);
      sel3_n = 4'b1011; EA = 15'h0003; RDn = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge DSPCLK);
         check("lat3 oe", 16'(oe3), 16'(k >= 4));
         if (k >= 4)
            check("lat3 data", do3, 16'h3C3C);
      end
      RDn = 1'b1; sel3_n = 4'hF;
      @(negedge DSPCLK);
      @(negedge DSPCLK);
      check("lat3 rd_cnt", rdc3, 16'd1);
      check("lat3 wr_cnt", wrc3, 16'd1);

      // PPclr during a write: discarded, counters cleared
      @(negedge DSPCLK);
      sel_n = 4'b1101; EA = 15'h0012; ED_in = 16'h5555; WRn = 1'b0;
      @(negedge DSPCLK);
      PPclr = 1'b1;
      #1;
      check("ppclr oe", 16'(oe1), 16'd0);
      check_state("ppclr", 16'd0, 16'd0, 4'b0000);
      check("ppclr u3 rd_cnt", rdc3, 16'd0);
      WRn = 1'b1; sel_n = 4'hF;
      @(negedge DSPCLK);
      PPclr = 1'b0;
      bus_read(4'b1101, 15'h0012, 2, 1'b1, 16'hA5C3);
      check_state("after ppclr", 16'd1, 16'd0, 4'b0000);

      // PPclr while driving: oe drops without a clock edge
      @(negedge DSPCLK);
      sel_n = 4'b1101; EA = 15'h0012; RDn = 1'b0;
      @(negedge DSPCLK);
      @(negedge DSPCLK);
      check("drive oe", 16'(oe1), 16'd1);
      PPclr = 1'b1;
      #1 check("async oe drop", 16'(oe1), 16'd0);
      RDn = 1'b1; sel_n = 4'hF;
      @(negedge DSPCLK);
      PPclr = 1'b0;

      // read counter saturation
      force u1.rd_cnt = 16'hFFFE;
      #1 release u1.rd_cnt;
      for (int i = 0; i < 3; i++) begin
         bus_read(4'b1101, 15'h0012, 2, 1'b1, 16'hA5C3);
         check("rd_cnt sat", rdc1, 16'hFFFF);
      end

      @(negedge DSPCLK);
      PPclr = 1'b1;
      @(negedge DSPCLK);
      PPclr = 1'b0;
      m_rd = '0; m_wr = '0; m_err = '0;
      for (int i = 0; i < 16; i++) m_io[i] = '0;

      for (int t = 0; t < 300; t++) begin
         logic [3:0]  s;
         int          sp;
         logic [14:0] a;
         logic [15:0] d, exp;
         int unsigned kind, key;
         logic        known;
         if ($urandom_range(0, 9) == 0) begin
            pulse_clr();
            m_err = '0;
         end
         s  = sel_tab[$urandom_range(0, 6)];
         sp = resolve(s);
         a  = 15'($urandom);
         if (sp == 2)
            a[10:4] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(1, 127)) : 7'd0;
         else
            a[9:0] = 10'($urandom_range(0, 15) * 61);
         key  = a[9:0];
         d    = 16'($urandom);
         kind = $urandom_range(0, 9);
         if ($countones(~s) > 1) m_err[1] = 1'b1;
         if (kind < 4) begin
            bus_write(s, a, d, $urandom_range(1, 3));
            if (sp == 0) m_pm[key] = d;
            else if (sp == 1) m_dm[key] = d;
            else if (a[10:4] == 7'd0) m_io[a[3:0]] = d;
            m_wr = sat(m_wr);
         end else if (kind < 9) begin
            known = 1'b1; exp = '0;
            if (sp == 0) begin
               known = m_pm.exists(key);
               if (known) exp = m_pm[key];
            end else if (sp == 1) begin
               known = m_dm.exists(key);
               if (known) exp = m_dm[key];
            end else begin
               exp = (a[10:4] == 7'd0) ? m_io[a[3:0]] : 16'h0000;
            end
            bus_read(s, a, $urandom_range(2, 4), known, exp);
            m_rd = sat(m_rd);
         end else begin
            bus_read(s, a, 1, 1'b0, 16'h0000);
            m_err[2] = 1'b1;
         end
         check_state($sformatf("rnd%0d", t), m_rd, m_wr, m_err);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
